mat_packet_engine: RTL and testbench



---
 rtl/mat_packet_engine.sv | 157 +++++++++++++++
 tb/tb_mat_packet_engine.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mat_packet_engine.sv
// rtl/mat_packet_engine.sv - checksummed UART hyperpacket parser and responder for the DIMxDIM multiplier
// Optional inter-byte timeout enabled by defining MAT_PKT_TIMEOUT_EN.
module mat_packet_engine #(
  parameter int         DIM            = 2,
  parameter logic [7:0] OPCODE         = 8'hFF,
  parameter logic [7:0] ERR_CODE       = 8'hEE,
  parameter int         TIMEOUT_CYCLES = 1200000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_valid,
  output logic [7:0]             tx_byte,
  output logic                   tx_send,
  input  logic                   tx_busy,
  output logic [8*DIM*DIM-1:0]   a_flat,
  output logic [8*DIM*DIM-1:0]   b_flat,
  output logic                   mul_start,
  input  logic                   mul_done,
  input  logic [8*DIM*DIM-1:0]   c_flat,
  output logic                   busy,
  output logic                   err_led
);

  localparam int N  = DIM * DIM;
  localparam int IW = $clog2(N + 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] LAST_TX  = IW'(N + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MAT_ID, S_JOB, S_DATA, S_CSUM, S_COMPUTE, S_SEND, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic             job_open, mat_sel;
  logic [7:0]       job_id, sum;
  logic [1:0]       err_code;
  logic [IW-1:0]    idx, tx_cnt;
  logic [8*N-1:0]   shadow, c_buf;
  logic [7:0]       resp [N+2];
  logic             send_ok, parsing, timeout;

  assign busy    = (state_q == S_COMPUTE) || (state_q == S_SEND) || (state_q == S_ERR);
  assign parsing = (state_q == S_MAT_ID) || (state_q == S_JOB) ||
                   (state_q == S_DATA) || (state_q == S_CSUM);
  // uart raises tx_busy one cycle late, so never send in the cycle after a send
  assign send_ok = !tx_busy && !tx_send;

`ifdef MAT_PKT_TIMEOUT_EN
  logic [31:0] to_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  to_cnt <= '0;
    else if (rx_valid || !parsing) to_cnt <= '0;
    else if (!timeout)           to_cnt <= to_cnt + 32'd1;
  end
  assign timeout = parsing && !rx_valid && (to_cnt >= 32'(TIMEOUT_CYCLES));
`else
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    resp[0] = job_id;
    resp[N+1] = job_id;
    for (int i = 0; i < N; i++) begin
      resp[i+1]  = c_buf[8*i +: 8];
      resp[N+1]  = resp[N+1] + c_buf[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (rx_valid && rx_byte == OPCODE) state_d = S_MAT_ID;
      S_MAT_ID:  if (rx_valid) state_d = (rx_byte == {7'd0, job_open}) ? S_JOB : S_ERR;
      S_JOB:     if (rx_valid) state_d = (mat_sel && rx_byte != job_id) ? S_ERR : S_DATA;
      S_DATA:    if (rx_valid && idx == LAST_IDX) state_d = S_CSUM;
      S_CSUM:    if (rx_valid) state_d = (rx_byte != sum) ? S_ERR : (mat_sel ? S_COMPUTE : S_IDLE);
      S_COMPUTE: if (mul_done) state_d = S_SEND;
      S_SEND:    if (send_ok && tx_cnt == LAST_TX) state_d = S_IDLE;
      S_ERR:     if (send_ok && tx_cnt == IW'(1)) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (timeout) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_open <= 1'b0; mat_sel <= 1'b0; job_id <= '0; sum <= '0; err_code <= '0;
      idx <= '0; tx_cnt <= '0; shadow <= '0; c_buf <= '0;
      a_flat <= '0; b_flat <= '0; tx_byte <= '0; tx_send <= 1'b0;
      mul_start <= 1'b0; err_led <= 1'b0;
    end else begin
      tx_send   <= 1'b0;
      mul_start <= 1'b0;
      if (state_q != S_SEND && state_q != S_ERR) tx_cnt <= '0;
      if (timeout) begin
        job_open <= 1'b0;
        idx      <= '0;
      end else begin
        case (state_q)
          S_IDLE: sum <= '0;
          S_MAT_ID: if (rx_valid) begin
            mat_sel  <= rx_byte[0];
            sum      <= rx_byte;
            err_code <= 2'd1;
          end
          S_JOB: if (rx_valid) begin
            sum      <= sum + rx_byte;
            idx      <= '0;
            err_code <= 2'd2;
            if (!mat_sel) job_id <= rx_byte;
          end
          S_DATA: if (rx_valid) begin
            shadow[8*idx +: 8] <= rx_byte;
            sum <= sum + rx_byte;
            idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
          end
          S_CSUM: if (rx_valid) begin
            err_code <= 2'd3;
            if (rx_byte == sum) begin
              if (mat_sel) begin
                b_flat    <= shadow;
                mul_start <= 1'b1;
              end else begin
                a_flat   <= shadow;
                job_open <= 1'b1;
              end
            end
          end
          S_COMPUTE: if (mul_done) c_buf <= c_flat;
          S_SEND: if (send_ok) begin
            tx_send <= 1'b1;
            tx_byte <= resp[tx_cnt];
            tx_cnt  <= tx_cnt + IW'(1);
            if (tx_cnt == LAST_TX) job_open <= 1'b0;
          end
          S_ERR: if (send_ok) begin
            tx_send <= 1'b1;
            tx_byte <= (tx_cnt == '0) ? ERR_CODE : {6'd0, err_code};
            tx_cnt  <= tx_cnt + IW'(1);
            if (tx_cnt == IW'(1)) begin
              err_led  <= ~err_led;
              job_open <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mat_packet_engine.sv
// tb/tb_mat_packet_engine.sv - scoreboard bench for mat_packet_engine (DIM=2)
module tb_mat_packet_engine;
  localparam int DIM = 2;
  localparam int N   = DIM * DIM;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     rx_byte;
  logic           rx_valid;
  logic [7:0]     tx_byte;
  logic           tx_send;
  logic           tx_busy;
  logic [8*N-1:0] a_flat, b_flat, c_flat;
  logic           mul_start, mul_done, busy, err_led;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] sb[$];
  logic [8*N-1:0] tb_a, tb_b;
  logic busy_seen = 1'b0;
  logic send_prev = 1'b0;

  mat_packet_engine #(.DIM(DIM), .OPCODE(8'hFF), .ERR_CODE(8'hEE), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_send(tx_send), .tx_busy(tx_busy),
    .a_flat(a_flat), .b_flat(b_flat), .mul_start(mul_start), .mul_done(mul_done),
    .c_flat(c_flat), .busy(busy), .err_led(err_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8*N-1:0] matmul(input logic [8*N-1:0] a, input logic [8*N-1:0] b);
    logic [7:0] acc;
    matmul = '0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        acc = 8'd0;
        for (int k = 0; k < DIM; k++) acc = acc + a[8*(r*DIM+k) +: 8] * b[8*(k*DIM+c) +: 8];
        matmul[8*(r*DIM+c) +: 8] = acc;
      end
  endfunction

  task automatic push_resp(input logic [7:0] job, input logic [8*N-1:0] c);
    logic [7:0] s;
    s = job;
    sb.push_back(job);
    for (int i = 0; i < N; i++) begin
      sb.push_back(c[8*i +: 8]);
      s = s + c[8*i +: 8];
    end
    sb.push_back(s);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] mat, input logic [7:0] job,
                          input logic [8*N-1:0] el, input logic [7:0] adj);
    logic [7:0] s;
    s = mat + job;
    send_byte(8'hFF);
    send_byte(mat);
    send_byte(job);
    for (int i = 0; i < N; i++) begin
      send_byte(el[8*i +: 8]);
      s = s + el[8*i +: 8];
    end
    send_byte(s + adj);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 3000), 64'd1);
  endtask

  task automatic run_job(input logic [7:0] job, input logic [8*N-1:0] a, input logic [8*N-1:0] b);
    tb_a = a;
    tb_b = b;
    send_pkt(8'd0, job, a, 8'd0);
    push_resp(job, matmul(a, b));
    send_pkt(8'd1, job, b, 8'd0);
  endtask

  // multiplier: result 3 cycles after mul_start, computed from the bench's own operands
  initial begin
    mul_done = 1'b0;
    c_flat = '0;
    forever begin
      @(negedge clk);
      if (mul_start) begin
        repeat (2) @(negedge clk);
        c_flat = matmul(tb_a, tb_b);
        mul_done = 1'b1;
        @(negedge clk);
        mul_done = 1'b0;
      end
    end
  end

  always @(posedge clk) busy_seen <= tx_busy;

  always @(negedge clk) begin
    if (rst_n && tx_send) begin
      chk("tx_guard", {62'd0, busy_seen, send_prev}, 64'd0);
      compared++;
      assert (sb.size() != 0) else begin
        mismatched++;
        $error("FAIL tx_extra observed=%0h expected=none", tx_byte);
      end
      if (sb.size() != 0) chk("tx_byte", 64'(tx_byte), 64'(sb.pop_front()));
    end
    send_prev = tx_send;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_byte = '0; rx_valid = 1'b0; tx_busy = 1'b0;
    tb_a = '0; tb_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_send", 64'(tx_send), 64'd0);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_a_flat", 64'(a_flat), 64'd0);
    chk("rst_b_flat", 64'(b_flat), 64'd0);
    chk("rst_tx_byte", 64'(tx_byte), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_led", 64'(err_led), 64'd0);

    // bad checksum on A
    sb.push_back(8'hEE); sb.push_back(8'h03);
    send_pkt(8'd0, 8'h07, 32'h04030201, 8'd1);
    wait_drain("drain_badcsum");
    chk("badcsum_err_led", 64'(err_led), 64'd1);
    chk("badcsum_a_flat", 64'(a_flat), 64'd0);

    // nominal multiply with literal expected response
    tb_a = 32'h04030201; tb_b = 32'h08070605;
    send_pkt(8'd0, 8'h07, 32'h04030201, 8'd0);
    chk("nom_a_flat", 64'(a_flat), 64'h04030201);
    sb.push_back(8'h07); sb.push_back(8'h13); sb.push_back(8'h16);
    sb.push_back(8'h2B); sb.push_back(8'h32); sb.push_back(8'h8D);
    send_pkt(8'd1, 8'h07, 32'h08070605, 8'd0);
    chk("nom_b_flat", 64'(b_flat), 64'h08070605);
    wait_drain("drain_nominal");
    chk("nom_idle", 64'(busy), 64'd0);

    // job id mismatch, then a clean job 09
    send_pkt(8'd0, 8'h07, 32'h0A090807, 8'd0);
    sb.push_back(8'hEE); sb.push_back(8'h02);
    send_byte(8'hFF); send_byte(8'h01); send_byte(8'h08);
    wait_drain("drain_jobmis");
    chk("jobmis_err_led", 64'(err_led), 64'd0);
    run_job(8'h09, 32'h11100F0E, 32'h05040302);
    wait_drain("drain_job09");

    // B while no job open, preceded by noise
    send_byte(8'h00); send_byte(8'h55);
    sb.push_back(8'hEE); sb.push_back(8'h01);
    send_pkt(8'd1, 8'h09, 32'h01020304, 8'd0);
    wait_drain("drain_order");
    chk("order_err_led", 64'(err_led), 64'd1);

    // transmitter back-pressure during SEND
    begin
      int n = 0;
      run_job(8'h21, 32'h20304050, 32'h09080706);
      while (sb.size() == N + 2 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("bp_first_tx", 64'(n < 200), 64'd1);
      tx_busy = 1'b1;
      repeat (50) @(negedge clk);
      chk("bp_held", 64'(sb.size()), 64'(N + 1));
      tx_busy = 1'b0;
      wait_drain("drain_bp");
    end

    // reset mid-packet
    send_byte(8'hFF); send_byte(8'h00); send_byte(8'h07);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_a_flat", 64'(a_flat), 64'd0);
    chk("mid_rst_b_flat", 64'(b_flat), 64'd0);
    chk("mid_rst_err_led", 64'(err_led), 64'd0);
    chk("mid_rst_tx", {56'd0, tx_byte}, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(8'h33, 32'h03050709, 32'h02040608);
    wait_drain("drain_after_rst");

`ifdef MAT_PKT_TIMEOUT_EN
    // 150-cycle gap mid-DATA returns to IDLE silently
    send_byte(8'hFF); send_byte(8'h00); send_byte(8'h44); send_byte(8'h01);
    repeat (150) @(negedge clk);
    chk("timeout_idle", 64'(busy), 64'd0);
    chk("timeout_no_tx", 64'(sb.size()), 64'd0);
    run_job(8'h44, 32'h01010101, 32'h02020202);
    wait_drain("drain_timeout");
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
